// File: rtl/prog_loader.sv
// prog_loader: assembles little-endian words from a byte stream and writes them into instruction memory.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       words_loaded
);
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [1:0] {S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
    localparam state_t S_END = S_DONE;
`endif
    localparam logic [31:0] MAX_N = 32'(DEPTH - BASE_ADDR);

    state_t              r_state, w_next;
    logic [1:0]          r_bidx;
    logic [23:0]         r_word;
    logic [31:0]         r_n, r_cnt, r_wdata;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         w_word;
    logic                w_acc, w_wend, w_last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign rx_ready     = rst && r_state != S_DONE && r_state != S_ERR;
    assign done         = r_state == S_DONE;
    assign err          = r_state == S_ERR;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_cnt;
    assign w_acc        = rx_valid && rx_ready && !start;
    assign w_word       = {rx_data, r_word};
    assign w_wend       = w_acc && r_bidx == 2'd3;
    assign w_last       = r_cnt + 32'd1 == r_n;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_HDR;
        else      r_state <= w_next;
    end

    // next-state: header decides load/done/error, last word or checksum closes the stream
    always_comb begin
        w_next = r_state;
        if (start) w_next = S_HDR;
        else case (r_state)
            S_HDR:  if (w_wend) w_next = (w_word == 32'd0) ? S_END : (w_word > MAX_N) ? S_ERR : S_LOAD;
            S_LOAD: if (w_wend && w_last) w_next = S_END;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: if (w_acc) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
`endif
            default: ;
        endcase
    end

    // byte assembly, header capture and the one-cycle write strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bidx  <= 2'd0;
            r_word  <= 24'd0;
            r_n     <= 32'd0;
            r_cnt   <= 32'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_addr  <= ADDR_W'(BASE_ADDR);
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_bidx <= 2'd0;
                r_cnt  <= 32'd0;
            end else if (w_acc) begin
                r_bidx <= r_bidx + 2'd1;
                r_word <= w_word[31:8];
                if (r_state == S_HDR && r_bidx == 2'd3) r_n <= w_word;
                if (r_state == S_LOAD && r_bidx == 2'd3) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                    r_addr  <= ADDR_W'(32'(BASE_ADDR) + r_cnt);
                    r_cnt   <= r_cnt + 32'd1;
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // running XOR of payload bytes, cleared on restart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           r_csum <= 8'd0;
        else if (start)                     r_csum <= 8'd0;
        else if (w_acc && r_state == S_LOAD) r_csum <= r_csum ^ rx_data;
    end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized program streams checked against a word-list reference model.
module tb_prog_loader;
    localparam int DEPTH = 16384;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready, imem_we, done, err;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata, words_loaded;
    int          total = 0, bad = 0, cyc = 0, c0;
    logic [7:0]  cs;
    logic [31:0] prog[$];

    prog_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (rx_ready !== 1'b1) chk("ready_timeout", 32'(rx_ready), 32'd1);
        else @(negedge clk);
    endtask

    task automatic gap(input int gmax);
        int k = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        if (k > 0) begin
            rx_valid = 1'b0;
            repeat (k) @(negedge clk);
        end
    endtask

    task automatic send_header(input int n, input int gmax);
        logic [31:0] v = 32'(n);
        for (int j = 0; j < 4; j++) begin
            gap(gmax);
            send(v[7:0]);
            v = v >> 8;
        end
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int gmax);
        logic [31:0] v = w;
        for (int j = 0; j < 4; j++) begin
            gap(gmax);
            send(v[7:0]);
            cs = cs ^ v[7:0];
            if (j < 3) chk("we_idle", 32'(imem_we), 32'd0);
            v = v >> 8;
        end
        chk("we_pulse", 32'(imem_we), 32'd1);
        chk("addr", 32'(imem_addr), 32'(idx));
        chk("wdata", imem_wdata, w);
        chk("words", words_loaded, 32'(idx + 1));
    endtask

    task automatic load_prog(input int gmax);
        int n = prog.size();
        cs = 8'd0;
        send_header(n, gmax);
        chk("hdr_no_we", 32'(imem_we), 32'd0);
        for (int i = 0; i < n; i++) send_word(i, prog[i], gmax);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("csum_wait", 32'(done), 32'd0);
        gap(gmax);
        send(cs);
`endif
        rx_valid = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("err", 32'(err), 32'd0);
        chk("rdy_done", 32'(rx_ready), 32'd0);
        chk("words_final", words_loaded, 32'(n));
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("st_done", 32'(done), 32'd0);
        chk("st_err", 32'(err), 32'd0);
        chk("st_words", words_loaded, 32'd0);
        chk("st_rdy", 32'(rx_ready), 32'd1);
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        #12;
        chk("rst_rdy", 32'(rx_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_words", words_loaded, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(rx_ready), 32'd1);

        prog = '{32'h00100513, 32'h0000006F};
        load_prog(0);

        pulse_start;
        prog.delete();
        load_prog(0);
        chk("n0_we", 32'(imem_we), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_start;
        send_header(0, 0);
        send(8'h01);
        rx_valid = 1'b0;
        chk("n0_bad_csum_err", 32'(err), 32'd1);
        chk("n0_bad_csum_done", 32'(done), 32'd0);
`endif

        pulse_start;
        send_header(DEPTH + 1, 0);
        rx_valid = 1'b0;
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_rdy", 32'(rx_ready), 32'd0);
        chk("ovf_we", 32'(imem_we), 32'd0);
        chk("ovf_words", words_loaded, 32'd0);
        pulse_start;
        rand_prog(1);
        load_prog(0);

        pulse_start;
        send_header(DEPTH, 0);
        rx_valid = 1'b0;
        chk("max_err", 32'(err), 32'd0);
        chk("max_rdy", 32'(rx_ready), 32'd1);

        pulse_start;
        send_header(3, 0);
        send(8'h13);
        send(8'h05);
        rx_data  = 8'hAA;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("abort_words", words_loaded, 32'd0);
        chk("abort_rdy", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_we", 32'(imem_we), 32'd0);
            @(negedge clk);
        end
        rand_prog(1);
        load_prog(0);

        pulse_start;
        rand_prog(1);
        c0 = cyc;
        load_prog(0);
        chk("b2b_cycles", 32'(cyc - c0), 32'(8 + CS));

        for (int t = 0; t < 12; t++) begin
            pulse_start;
            rand_prog(int'($urandom_range(5, 1)));
            load_prog(2);
        end

        pulse_start;
        rand_prog(3);
        cs = 8'd0;
        send_header(3, 0);
        send_word(0, prog[0], 0);
        send_word(1, prog[1], 0);
        rx_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_words", words_loaded, 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_rdy", 32'(rx_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_rel_words", words_loaded, 32'd0);
        chk("arst_rel_rdy", 32'(rx_ready), 32'd1);
        rand_prog(1);
        load_prog(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
